// File: rtl/user_gpio_ctrl_if.sv
// PS-side GPIO/EMIO bundle for user_gpio_ctrl.
// master = PS, slave = controller.
interface user_gpio_ctrl_if;
  logic [1:0] zynq_gpio_input;
  logic [3:0] zynq_gpio_output;
  logic [3:0] zynq_led_mode;
  logic [1:0] irq_en;
  logic       irq_ack;
  logic [1:0] irq_status;
  logic       irq;

  modport master (
    input  zynq_gpio_input,
    output zynq_gpio_output,
    output zynq_led_mode,
    output irq_en,
    output irq_ack,
    input  irq_status,
    input  irq
  );

  modport slave (
    output zynq_gpio_input,
    input  zynq_gpio_output,
    input  zynq_led_mode,
    input  irq_en,
    input  irq_ack,
    output irq_status,
    output irq
  );
endinterface

// File: rtl/user_gpio_ctrl.sv
// User GPIO controller: input sync/debounce, edge irq,
// and PS-driven pin outputs with optional blink.
module user_gpio_ctrl #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int BLINK_DIV       = 25000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       gpio_input,
  output logic [3:0]       gpio_output,
  user_gpio_ctrl_if.slave  ps
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int BW =
    (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [CW-1:0] CLAST =
    CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [BW-1:0] BLAST =
    BW'(BLINK_DIV - 1);

  logic [1:0]    meta;
  logic [1:0]    sync;
  logic [1:0]    stable;
  logic [1:0]    upd;
  logic [1:0]    status;
  logic [CW-1:0] cnt [2];
  logic [BW-1:0] bcnt;
  logic          phase;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      sync <= '0;
    end else begin
      meta <= gpio_input;
      sync <= meta;
    end
  end

  // upd marks the edge on which a channel's stable level flips
  always_comb begin
    upd = '0;
    for (int i = 0; i < 2; i++) begin
      upd[i] = (sync[i] != stable[i]) &&
               (cnt[i] == CLAST);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable <= '0;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (upd[i]) begin
          stable[i] <= sync[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // a new edge outranks a simultaneous ack
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status <= '0;
    end else begin
      status <= (ps.irq_ack ? 2'b00 : status) |
                (upd & ps.irq_en);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt  <= '0;
      phase <= 1'b0;
    end else if (bcnt == BLAST) begin
      bcnt  <= '0;
      phase <= ~phase;
    end else begin
      bcnt <= bcnt + BW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gpio_output <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        gpio_output[i] <= ps.zynq_led_mode[i] ?
          (ps.zynq_gpio_output[i] & phase) :
          ps.zynq_gpio_output[i];
      end
    end
  end

  assign ps.zynq_gpio_input = stable;
  assign ps.irq_status      = status;
  assign ps.irq             = |status;

endmodule

// File: tb/tb_user_gpio_ctrl.sv
// Bench for user_gpio_ctrl: directed scenarios plus
// random traffic against a history-based reference model.
module tb_user_gpio_ctrl;

  localparam int D = 4;
  localparam int B = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] gpio_input;
  logic [3:0] gpio_output;

  user_gpio_ctrl_if bus ();

  user_gpio_ctrl #(
    .DEBOUNCE_CYCLES (D),
    .BLINK_DIV       (B)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .gpio_input  (gpio_input),
    .gpio_output (gpio_output),
    .ps          (bus.slave)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  int         k;
  logic [1:0] hist  [$];
  logic [1:0] seenq [$];
  logic [1:0] m_stable;
  logic [1:0] m_status;
  logic [3:0] m_out;

  task automatic chk(input string tag,
                     input logic [3:0] obs,
                     input logic [3:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    k = 0;
    hist.delete();
    seenq.delete();
    m_stable = '0;
    m_status = '0;
    m_out    = '0;
  endtask

  // Pin level seen downstream at edge k is the pin sampled
  // two edges earlier; a level flips once D consecutive
  // seen samples all disagree with it.
  task automatic model_edge();
    logic [1:0] seen;
    logic [1:0] upd;
    logic       all;
    logic       ph;
    k++;
    seen = (k >= 3) ? hist[k-3] : 2'b00;
    seenq.push_back(seen);
    hist.push_back(gpio_input);
    upd = '0;
    if (seenq.size() >= D) begin
      for (int i = 0; i < 2; i++) begin
        all = 1'b1;
        for (int j = 0; j < D; j++) begin
          if (seenq[seenq.size()-1-j][i] == m_stable[i])
            all = 1'b0;
        end
        upd[i] = all;
      end
    end
    m_stable = m_stable ^ upd;
    m_status = (bus.irq_ack ? 2'b00 : m_status) |
               (upd & bus.irq_en);
    ph = (((k - 1) / B) % 2) == 1;
    for (int i = 0; i < 4; i++) begin
      m_out[i] = bus.zynq_led_mode[i] ?
        (bus.zynq_gpio_output[i] & ph) :
        bus.zynq_gpio_output[i];
    end
  endtask

  task automatic check_all();
    chk("zgi", {2'b00, bus.zynq_gpio_input},
        {2'b00, m_stable});
    chk("status", {2'b00, bus.irq_status},
        {2'b00, m_status});
    chk("irq", {3'b000, bus.irq},
        {3'b000, |m_status});
    chk("gpio", gpio_output, m_out);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_edge();
    #1;
    if (!rst) check_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_gpio"}, gpio_output, 4'h0);
    chk({tag, "_zgi"},
        {2'b00, bus.zynq_gpio_input}, 4'h0);
    chk({tag, "_st"},
        {2'b00, bus.irq_status}, 4'h0);
    chk({tag, "_irq"}, {3'b000, bus.irq}, 4'h0);
  endtask

  task automatic pulse_ack();
    bus.irq_ack = 1'b1;
    tick();
    bus.irq_ack = 1'b0;
  endtask

  int hold;

  initial begin
    rst                  = 1'b1;
    gpio_input           = '0;
    bus.zynq_gpio_output = '0;
    bus.zynq_led_mode    = '0;
    bus.irq_en           = '0;
    bus.irq_ack          = 1'b0;
    model_reset();
    #1;
    chk_zero("rst_init");
    ticks(2);
    rst = 1'b0;

    // clean edge on channel 0
    bus.irq_en = 2'b01;
    gpio_input = 2'b01;
    ticks(5);
    chk("edge_early", {2'b00, bus.zynq_gpio_input}, 4'h0);
    tick();
    chk("edge_zgi", {2'b00, bus.zynq_gpio_input}, 4'h1);
    chk("edge_st", {2'b00, bus.irq_status}, 4'h1);
    chk("edge_irq", {3'b000, bus.irq}, 4'h1);
    pulse_ack();
    chk("ack_irq", {3'b000, bus.irq}, 4'h0);

    // glitch on channel 1, then a passing pulse
    gpio_input = 2'b11;
    ticks(3);
    gpio_input = 2'b01;
    ticks(8);
    chk("glitch_zgi", {2'b00, bus.zynq_gpio_input}, 4'h1);
    chk("glitch_st", {2'b00, bus.irq_status}, 4'h0);
    bus.irq_en = 2'b11;
    gpio_input = 2'b11;
    ticks(4);
    gpio_input = 2'b01;
    ticks(2);
    chk("pulse_zgi", {2'b00, bus.zynq_gpio_input}, 4'h3);
    chk("pulse_st", {2'b00, bus.irq_status}, 4'h2);
    ticks(8);
    chk("pulse_back", {2'b00, bus.zynq_gpio_input}, 4'h1);

    // ack on the same edge as a channel 0 update
    pulse_ack();
    gpio_input = 2'b00;
    ticks(5);
    bus.irq_ack = 1'b1;
    tick();
    bus.irq_ack = 1'b0;
    chk("coll_st", {2'b00, bus.irq_status}, 4'h1);
    chk("coll_zgi", {2'b00, bus.zynq_gpio_input}, 4'h0);

    // disabled channel still updates its level
    bus.irq_en = 2'b00;
    pulse_ack();
    gpio_input = 2'b10;
    ticks(6);
    chk("dis_zgi", {2'b00, bus.zynq_gpio_input}, 4'h2);
    chk("dis_st", {2'b00, bus.irq_status}, 4'h0);

    // blink on outputs 0 and 2
    bus.zynq_gpio_output = 4'b1111;
    bus.zynq_led_mode    = 4'b0101;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("blink_steady",
          {2'b00, gpio_output[3], gpio_output[1]}, 4'h3);
    end

    // gated and direct drive
    bus.zynq_led_mode    = 4'b1111;
    bus.zynq_gpio_output = 4'b0000;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("gated", gpio_output, 4'h0);
    end
    bus.zynq_gpio_output = 4'b1000;
    bus.zynq_led_mode    = 4'b0000;
    tick();
    chk("direct", gpio_output, 4'h8);

    // reset mid-count with status pending
    bus.irq_en = 2'b01;
    gpio_input = 2'b11;
    ticks(6);
    chk("pre_rst_st", {2'b00, bus.irq_status}, 4'h1);
    gpio_input = 2'b10;
    ticks(3);
    #2;
    rst = 1'b1;
    #1;
    chk_zero("rst_mid");
    model_reset();
    ticks(2);
    gpio_input           = 2'b00;
    bus.zynq_gpio_output = 4'b0000;
    rst = 1'b0;
    ticks(10);
    chk_zero("rst_after");

    // random traffic
    hold = 0;
    for (int i = 0; i < 600; i++) begin
      if (hold == 0) begin
        gpio_input[$urandom_range(0, 1)] ^= 1'b1;
        hold = $urandom_range(1, 7);
      end
      hold--;
      if ((i % 50) == 0)
        bus.irq_en = 2'($urandom_range(0, 3));
      bus.irq_ack = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 9) == 0) begin
        bus.zynq_gpio_output = 4'($urandom);
        bus.zynq_led_mode    = 4'($urandom);
      end
      if (i == 300) begin
        #2;
        rst = 1'b1;
        #1;
        chk_zero("rst_rand");
        model_reset();
        tick();
        rst = 1'b0;
      end
      tick();
    end
    bus.irq_ack = 1'b0;

    // pins high through reset
    bus.irq_en = 2'b11;
    gpio_input = 2'b11;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    tick();
    rst = 1'b0;
    ticks(5);
    chk("post_early", {2'b00, bus.zynq_gpio_input}, 4'h0);
    tick();
    chk("post_zgi", {2'b00, bus.zynq_gpio_input}, 4'h3);
    chk("post_st", {2'b00, bus.irq_status}, 4'h3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/user_gpio_ctrl.md
# user_gpio_ctrl

Controller for the user GPIO path between the FPGA pins and the Zynq PS. It synchronises and debounces the 2 pin inputs, raises a maskable edge interrupt to the PS, and drives the 4 pin outputs from PS-written values, with an optional per-output hardware blink mode. It sits between the pin-level GPIO wiring and the PS GPIO/EMIO interface, in a single clock domain.

## Interface
- DEBOUNCE_CYCLES, 50000: consecutive cycles a synchronised input must differ from its debounced level before the level updates; must be ≥1.
- BLINK_DIV, 25000000: cycles per blink half-period; must be ≥1.

- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- gpio_input  in  2  raw pin inputs, asynchronous to clk.
- zynq_gpio_input  out  2  debounced input levels for the PS to read.
- gpio_output  out  4  registered pin outputs.
- zynq_gpio_output  in  4  output values written by the PS.
- zynq_led_mode  in  4  per-output mode: 0 = direct, 1 = blink.
- irq_en  in  2  per-input interrupt enable.
- irq_ack  in  1  single-cycle pulse that clears all pending status.
- irq_status  out  2  pending-edge flags, one per input.
- irq  out  1  level interrupt: OR of irq_status.

## Operation
- Synchroniser:
  - 2-flop synchroniser per input; flops reset to 0.
  - Only the second flop output (sync) is used downstream.
- Debounce, per channel:
  - Holds a debounced level (stable) and a counter; width is $clog2(DEBOUNCE_CYCLES+1).
  - sync == stable: counter clears to 0.
  - sync != stable and counter == DEBOUNCE_CYCLES-1: stable <= sync and counter clears to 0.
  - Otherwise the counter increments.
  - A glitch shorter than DEBOUNCE_CYCLES resets the count and leaves stable unchanged.
  - zynq_gpio_input = stable.
- Edge interrupt:
  - When stable[i] updates and irq_en[i] = 1, irq_status[i] is set on that same edge.
  - Rising and falling edges are treated identically.
  - irq_en[i] = 0 suppresses setting the flag but does not clear an existing flag.
  - irq_ack clears both status bits.
  - If irq_ack and a new update on channel i occur in the same cycle, the set wins: irq_status[i] = 1 after that edge.
  - irq = |irq_status; it is combinational from registers and glitch-free.
- Blink generator:
  - A free-running counter counts 0..BLINK_DIV-1 and wraps.
  - On each wrap, the blink phase toggles.
  - The phase resets to 0.
- Output drive, registered:
  - gpio_output[i] <= zynq_led_mode[i] ? (zynq_gpio_output[i] & phase) : zynq_gpio_output[i].
  - A 0 in zynq_gpio_output forces the output off in both modes.
  - Mode changes take effect on the next edge; the blink phase is not restarted by a mode change.

## Timing
- Reset values:
  - gpio_output = 4'b0000, zynq_gpio_input = 2'b00, irq_status = 2'b00, irq = 0.
  - All counters and the blink phase are 0.
- Input latency:
  - A pin level held constant is first captured at edge E0.
  - sync changes after edge E1.
  - stable, zynq_gpio_input and irq_status update after edge E1+DEBOUNCE_CYCLES.
  - Total: DEBOUNCE_CYCLES+2 edges from the first sampling edge.
- Output latency: a zynq_gpio_output or zynq_led_mode change appears on gpio_output 1 edge later.
- Blink timing: the phase toggles every BLINK_DIV cycles, so a full blink period is 2·BLINK_DIV cycles. The first toggle occurs BLINK_DIV edges after reset deassertion.
- Reset mid-operation: rst asserted at any time immediately clears all state, including in-progress debounce counts and pending status. No edge is reported for the reset-induced change.
- Post-reset: if a pin sits at 1 through reset, one debounced 0->1 update (and irq if enabled) occurs DEBOUNCE_CYCLES+2 edges after rst deasserts. This is required behaviour.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4 and BLINK_DIV = 3.
- Reset check: assert rst mid-count with irq_status = 2'b01 -> all outputs 0 immediately. After release with pins at 0, outputs remain 0.
- Clean edge: irq_en = 2'b01; gpio_input[0] 0->1 and held -> zynq_gpio_input[0] = 1, irq_status = 2'b01 and irq = 1, exactly 6 edges after first sample. Pulse irq_ack -> irq = 0 next edge.
- Glitch rejection: gpio_input[1] high for 3 cycles, then low -> zynq_gpio_input[1] stays 0 and irq_status[1] stays 0. A 4-cycle pulse (post-sync) passes and sets irq_status[1] if enabled.
- Ack collision: irq_ack asserted on the same edge that channel 0 updates with irq_en[0] = 1 -> irq_status[0] = 1 afterwards. A disabled channel's edge -> flag not set, zynq_gpio_input still updates.
- Blink: zynq_gpio_output = 4'b1111, zynq_led_mode = 4'b0101 -> gpio_output[1] and gpio_output[3] constant 1. gpio_output[0] and gpio_output[2] alternate 0/1 every 3 cycles.
- Direct/gated output: zynq_led_mode = 4'b1111, zynq_gpio_output = 4'b0000 -> gpio_output = 0 for all cycles. Then write 4'b1000 with mode 4'b0000 -> gpio_output = 4'b1000 one edge later.
